// File: rtl/kara36_seq.sv
// One Karatsuba level: 2*HW x 2*HW multiply built from three sequential
// HW x HW products issued to an external leaf multiplier over a start/done level handshake.
module kara36_seq #(
  parameter int unsigned HW = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2*HW-1:0]   A,
  input  logic [2*HW-1:0]   B,
  output logic              done,
  output logic [4*HW-1:0]   P,
  output logic              m_start,
  output logic [HW-1:0]     m_a,
  output logic [HW-1:0]     m_b,
  input  logic              m_done,
  input  logic [2*HW-1:0]   m_p
);

  localparam int unsigned OW = 2 * HW;
  localparam int unsigned PW = 4 * HW;
  localparam int unsigned SW = HW + 1;

  typedef enum logic [3:0] {
    IDLE, REQ0, REL0, REQ1, REL1, REQ2, REL2, COMB, DONE
  } state_t;

  state_t        state;
  logic [HW-1:0] a1, a0, b1, b0;
  logic [SW-1:0] sa, sb;
  logic [OW-1:0] z2, z0, zs;

  // Half sums of the incoming operands, latched on accept
  logic [SW-1:0] sa_in_c, sb_in_c;
  assign sa_in_c = SW'(A[OW-1:HW]) + SW'(A[HW-1:0]);
  assign sb_in_c = SW'(B[OW-1:HW]) + SW'(B[HW-1:0]);

  // Recombination: restore the carry bits dropped from the leaf's (sa_l*sb_l)
  logic          ca, cb;
  logic [HW-1:0] sa_l, sb_l;
  logic [SW-1:0] cross_c;
  logic [PW-1:0] zm_c, mid_c, prod_c;

  assign ca      = sa[HW];
  assign cb      = sb[HW];
  assign sa_l    = sa[HW-1:0];
  assign sb_l    = sb[HW-1:0];
  assign cross_c = SW'(ca ? sb_l : {HW{1'b0}}) + SW'(cb ? sa_l : {HW{1'b0}});
  assign zm_c    = PW'(zs) + (PW'(cross_c) << HW) + (PW'(ca & cb) << OW);
  assign mid_c   = zm_c - PW'(z2) - PW'(z0);
  assign prod_c  = (PW'(z2) << OW) + (mid_c << HW) + PW'(z0);

  // Sequencer: three leaf requests, each released before the next is raised
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      P       <= '0;
      m_start <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
      a1      <= '0;
      a0      <= '0;
      b1      <= '0;
      b0      <= '0;
      sa      <= '0;
      sb      <= '0;
      z2      <= '0;
      z0      <= '0;
      zs      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a1      <= A[OW-1:HW];
            a0      <= A[HW-1:0];
            b1      <= B[OW-1:HW];
            b0      <= B[HW-1:0];
            sa      <= sa_in_c;
            sb      <= sb_in_c;
            m_a     <= A[OW-1:HW];
            m_b     <= B[OW-1:HW];
            m_start <= 1'b1;
            state   <= REQ0;
          end
        end
        REQ0: begin
          if (m_done) begin
            z2      <= m_p;
            m_start <= 1'b0;
            state   <= REL0;
          end
        end
        REL0: begin
          if (!m_done) begin
            m_a     <= a0;
            m_b     <= b0;
            m_start <= 1'b1;
            state   <= REQ1;
          end
        end
        REQ1: begin
          if (m_done) begin
            z0      <= m_p;
            m_start <= 1'b0;
            state   <= REL1;
          end
        end
        REL1: begin
          if (!m_done) begin
            m_a     <= sa_l;
            m_b     <= sb_l;
            m_start <= 1'b1;
            state   <= REQ2;
          end
        end
        REQ2: begin
          if (m_done) begin
            zs      <= m_p;
            m_start <= 1'b0;
            state   <= REL2;
          end
        end
        REL2: begin
          if (!m_done) begin
            state <= COMB;
          end
        end
        COMB: begin
          P     <= prod_c;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kara36_seq.sv
// Self-checking bench for kara36_seq with a behavioural level-handshake leaf multiplier.
module tb_kara36_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [35:0] A, B;
  logic        done;
  logic [71:0] P;
  logic        m_start;
  logic [17:0] m_a, m_b;
  logic        m_done;
  logic [35:0] m_p;

  int n_vec = 0;
  int n_err = 0;
  int leaf_lat = 0;
  int lcnt = 0;

  logic [71:0] exp_q[$];
  logic [35:0] req_q[$];
  logic        ms_q = 1'b0;
  logic [35:0] ops_q = '0;

  kara36_seq #(.HW(18)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .done(done), .P(P), .m_start(m_start), .m_a(m_a), .m_b(m_b),
    .m_done(m_done), .m_p(m_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaf model: done raised leaf_lat+1 cycles after request, cleared one cycle after release
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done <= 1'b0;
      m_p    <= '0;
      lcnt   <= 0;
    end else if (m_start && !m_done) begin
      if (lcnt >= leaf_lat) begin
        m_done <= 1'b1;
        m_p    <= 36'(m_a) * 36'(m_b);
        lcnt   <= 0;
      end else begin
        lcnt <= lcnt + 1;
      end
    end else if (!m_start) begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [35:0] mk(input logic [17:0] a, input logic [17:0] b);
    return {a, b};
  endfunction

  // Handshake monitor: log leaf requests, check rule and operand stability
  always @(negedge clk) begin
    if (!rst) begin
      if (m_start && !ms_q) begin
        req_q.push_back({m_a, m_b});
        chk("mstart_rise_mdone_low", 72'(m_done), 72'(0));
      end else if (m_start && ms_q) begin
        chk("leaf_ops_stable", 72'({m_a, m_b}), 72'(ops_q));
      end
    end
    ms_q  <= m_start;
    ops_q <= {m_a, m_b};
  end

  // drop_at < 0: hold start; hold = extra cycles done must stay high with start held
  task automatic do_op(input logic [35:0] a, input logic [35:0] b, input int drop_at,
                       input int hold, input bit chk_lat);
    int lat;
    logic [71:0] want;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    exp_q.push_back(72'(a) * 72'(b));
    lat = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == drop_at) start = 1'b0;
    end
    if (!done) begin
      chk("done_timeout", 72'(done), 72'(1));
      start = 1'b0;
      return;
    end
    if (chk_lat) chk("latency", 72'(lat), 72'(14));
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 72'(0), 72'(1));
    end else begin
      want = exp_q.pop_front();
      chk("product", P, want);
    end
    if (drop_at >= 0) begin
      @(negedge clk);
      chk("done_one_cycle", 72'(done), 72'(0));
    end else begin
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        chk("done_held", 72'(done), 72'(1));
        chk("p_held", P, 72'(a) * 72'(b));
      end
      start = 1'b0;
      @(negedge clk);
      chk("done_falls", 72'(done), 72'(0));
      chk("p_after_done", P, 72'(a) * 72'(b));
    end
  endtask

  initial begin
    logic [35:0] ra, rb;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) @(negedge clk);
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_p", P, 72'(0));
    chk("rst_mstart", 72'(m_start), 72'(0));
    chk("rst_ma", 72'(m_a), 72'(0));
    chk("rst_mb", 72'(m_b), 72'(0));
    rst = 1'b0;

    // Small operands, leaf request sequence, done hold for 5 cycles
    req_q.delete();
    do_op(36'd3, 36'd5, -1, 5, 1'b1);
    chk("req_count", 72'(req_q.size()), 72'(3));
    if (req_q.size() == 3) begin
      chk("req0_ops", 72'(req_q[0]), 72'(mk(18'd0, 18'd0)));
      chk("req1_ops", 72'(req_q[1]), 72'(mk(18'd3, 18'd5)));
      chk("req2_ops", 72'(req_q[2]), 72'(mk(18'd3, 18'd5)));
    end

    // Both carries set
    do_op(36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF, -1, 1, 1'b1);
    chk("max_sq_const", P, 72'hFF_FFFF_FFE0_0000_0001);

    // ca=1 with sa_l=0
    req_q.delete();
    do_op(36'h7_FFFF, 36'd5, -1, 2, 1'b1);
    chk("ca_only_const", P, 72'h27_FFFB);
    if (req_q.size() == 3)
      chk("req2_ca_ops", 72'(req_q[2]), 72'(mk(18'd0, 18'd5)));
    else
      chk("req_count_ca", 72'(req_q.size()), 72'(3));

    // Start dropped mid-operation, then a back-to-back op
    do_op(36'h1_2345_6789, 36'd2, 4, 0, 1'b1);
    chk("drop_const", P, 72'h2_468A_CF12);
    do_op(36'd1, 36'd1, -1, 1, 1'b1);

    // Async reset in REQ1 discards the operation
    @(negedge clk);
    A = 36'hA_BCDE_F012;
    B = 36'h3_4567_89AB;
    start = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_done", 72'(done), 72'(0));
    chk("midrst_p", P, 72'(0));
    chk("midrst_mstart", 72'(m_start), 72'(0));
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(36'd7, 36'd9, -1, 1, 1'b1);

    // Edge operand mixes
    do_op(36'd0, 36'hF_FFFF_FFFF, -1, 1, 1'b1);
    do_op(36'hF_FFFF_FFFF, 36'd1, -1, 1, 1'b1);
    do_op(36'h8_0000_0000, 36'h3_FFFF, -1, 1, 1'b1);

    // Random operands with varying leaf latency
    for (int i = 0; i < 12; i++) begin
      leaf_lat = (i < 4) ? 0 : int'($urandom_range(4, 0));
      ra = {4'($urandom), 32'($urandom)};
      rb = {4'($urandom), 32'($urandom)};
      do_op(ra, rb, (i % 3 == 0) ? 3 : -1, 1 + i % 3, leaf_lat == 0);
    end

    chk("scoreboard_drained", 72'(exp_q.size()), 72'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kara36_seq.md
Name: kara36_seq

Overview:
- One Karatsuba level above the 18x18 multiplier leaf. Multiplies two 36-bit operands into a 72-bit product.
- Splits each operand into 18-bit halves and issues three sub-products, one at a time, to a single external 18x18 leaf multiplier over that leaf's start/done level handshake.
- Recombines the three results into the final product.
- Sits directly upstream of the leaf: it feeds the leaf its operands and consumes its 36-bit results. It is the building block for the 64-bit tree.

Parameters:
- HW, 18, half width. Must equal the leaf operand width. Operand width is 2*HW; product width is 4*HW.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  level request; operands sampled when accepted
- A  in  36  multiplicand
- B  in  36  multiplier
- done  out  1  result valid; held until start seen low
- P  out  72  product A*B
- m_start  out  1  leaf request level
- m_a  out  18  leaf operand A
- m_b  out  18  leaf operand B
- m_done  in  1  leaf done level
- m_p  in  36  leaf product

Behaviour:
- Reset: async on rst. Forces done=0, P=0, m_start=0, m_a=0, m_b=0, state=IDLE, all internal registers 0.
  - Takes effect mid-operation in any state.
  - Leaf result in flight is discarded.
- Operand split: a1=A[35:18], a0=A[17:0], b1=B[35:18], b0=B[17:0].
  - sa=a1+a0 and sb=b1+b0, each 19 bits.
  - Carry bits ca=sa[18], cb=sb[18]; low parts sa_l=sa[17:0], sb_l=sb[17:0].
- States: IDLE, REQ0, REL0, REQ1, REL1, REQ2, REL2, COMB, DONE.
- IDLE: on start=1, latch a1, a0, b1, b0, sa, sb. Drive m_a=a1, m_b=b1, m_start<=1, go to REQ0.
- REQk (k=0,1,2): hold m_start=1 and the operands stable. When m_done=1, capture m_p, m_start<=0, go to RELk.
  - k=0: capture z2=a1*b1.
  - k=1: capture z0=a0*b0.
  - k=2: capture zs=sa_l*sb_l.
- RELk: wait for m_done=0, so the leaf is no longer busy.
  - Then REL0 -> REQ1 with m_a=a0, m_b=b0, m_start<=1.
  - REL1 -> REQ2 with m_a=sa_l, m_b=sb_l, m_start<=1.
  - REL2 -> COMB.
  - Never raise m_start while m_done=1.
- COMB (one cycle): full-width recombination, no truncation before the final 72 bits.
  - zm = zs + ((ca ? sb_l : 0) + (cb ? sa_l : 0)) << 18 + (ca & cb) << 36
  - mid = zm - z2 - z0, always >= 0, fits 38 bits.
  - P <= (z2 << 36) + (mid << 18) + z0
  - done <= 1, go to DONE.
- DONE: hold done=1 and P while start=1. When start=0, done<=0 and go to IDLE.
  - P holds its value until the next COMB or reset.
- Start dropped mid-operation: the operation still completes.
  - At completion done is high for exactly one cycle, then drops because start is low.
- Back-to-back operations: start must be seen low in DONE before the next operation. IDLE accepts start on the first cycle it is seen high.
- Latency with the standard leaf (done registered one cycle after start, cleared one cycle after start low):
  - Accept at edge 0; leaf products captured at edges 2, 6, 10.
  - COMB entered at edge 12; done=1 after edge 13.
  - Correctness must not depend on leaf latency. Any leaf obeying the level handshake works.
- Throughput: one operation per 15 cycles minimum (13 + DONE + IDLE).

Test Plan:
- A=3, B=5, start held -> done=1 after 13 cycles, P=15. m_start rises 3 times with (m_a,m_b)=(0,0), (3,5), (3,5).
- A=B=0xFFFFFFFFF -> P=0xFFFFFFFFE000000001. Covers ca=cb=1 correction.
- A=0x7FFFF (a1=1, a0=0x3FFFF, so ca=1, sa_l=0), B=5 -> P=0x27FFFB. Third leaf request has m_a=0, m_b=5.
- Drop start 4 cycles after accept, A=0x123456789, B=0x2 -> done high for exactly 1 cycle at cycle 13, P=0x2468ACF12. Next op with A=B=1 -> P=1.
- Assert rst during REQ1 -> same cycle: done=0, P=0, m_start=0. After release, A=7, B=9 completes with P=63.
- Handshake check: m_start never rises while m_done=1. done stays 1 for 5 cycles while start is held, and falls 1 cycle after start goes low.
